// File: rtl/generic_fifo_sc_param.sv
// Single-clock FIFO with registered status flags, sticky error flags
// and an optional first-word-fall-through read port.
module generic_fifo_sc_param #(
  parameter int DW        = 153,
  parameter int AW        = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0]   AE_C    = (AW + 1)'(AE_THRESH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_bad
    $error("generic_fifo_sc_param: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_bad
    $error("generic_fifo_sc_param: AE_THRESH out of range");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count_nxt;
  logic          wr_ok;
  logic          rd_ok;
  logic          flush;

  assign flush = ~rst | clr;
  // Acceptance uses only registered flags, so we&re at empty or full
  // resolves to exactly one side being accepted.
  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok) begin
      count_nxt = count + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + PTR_ONE;
      end
      if (rd_ok) begin
        rp <= rp + PTR_ONE;
      end
      if (we && full) begin
        overflow <= 1'b1;
      end
      if (re && empty) begin
        underflow <= 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = mem[rp];
  end else begin : g_std
    logic [DW-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (flush) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem[rp];
      end
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_generic_fifo_sc_param.sv
// Directed bench for generic_fifo_sc_param: scoreboarded standard-read
// instance plus a small first-word-fall-through instance.
module tb_generic_fifo_sc_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = '0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  logic       b_clr = 1'b0;
  logic [7:0] b_din = '0;
  logic       b_we  = 1'b0;
  logic       b_re  = 1'b0;
  logic [7:0] b_dout;
  logic       b_full, b_empty, b_af, b_ae;
  logic [2:0] b_count;
  logic       b_ovf, b_unf;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_unf = 0;

  always #5 clk = ~clk;

  generic_fifo_sc_param #(
    .DW(8), .AW(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
    .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  generic_fifo_sc_param #(
    .DW(8), .AW(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .din(b_din), .we(b_we),
    .re(b_re), .dout(b_dout), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == 4));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(n >= 3));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= 1));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  // One clock of instance A with scoreboard update.
  task automatic cyc(input string tag, input logic w, input logic r,
                     input logic [7:0] d);
    bit wok, rok;
    logic [7:0] e;
    wok = w && (q.size() < 4);
    rok = r && (q.size() > 0);
    if (w && q.size() == 4) m_ovf = 1;
    if (r && q.size() == 0) m_unf = 1;
    we = w; re = r; din = d;
    tick();
    we = 1'b0; re = 1'b0;
    if (rok) begin
      e = q.pop_front();
      chk({tag, ".dout"}, 32'(dout), 32'(e));
    end
    if (wok) q.push_back(d);
    chk_status(tag);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1; we = 1'b1; re = 1'b1;
    tick();
    clr = 1'b0; we = 1'b0; re = 1'b0;
    q.delete(); m_ovf = 0; m_unf = 0;
    chk_status(tag);
  endtask

  initial begin
    // Reset held 2 cycles with requests active
    rst = 1'b0; we = 1'b1; re = 1'b1; din = 8'hFF;
    b_we = 1'b1; b_re = 1'b1; b_din = 8'hEE;
    tick(); tick();
    rst = 1'b1; we = 1'b0; re = 1'b0; b_we = 1'b0; b_re = 1'b0;
    chk_status("rst");
    chk("rst.dout", 32'(dout), 32'h0);
    chk("rst.b_empty", 32'(b_empty), 32'h1);
    chk("rst.b_count", 32'(b_count), 32'h0);

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 4; i++) cyc("fill", 1, 0, 8'hA0 + 8'(i));
    cyc("ovf", 1, 0, 8'hBB);
    cyc("ovf_hold", 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc("drain", 0, 1, 8'h00);
    cyc("drain_hold", 0, 0, 8'h00);
    chk("drain_hold.dout", 32'(dout), 32'hA3);
    cyc("unf", 0, 1, 8'h00);
    do_clr("clr1");

    // Simultaneous read/write at mid, empty and full occupancy
    cyc("mid_w", 1, 0, 8'h10);
    cyc("mid_w", 1, 0, 8'h11);
    for (int i = 0; i < 5; i++) cyc("mid_wr", 1, 1, 8'h20 + 8'(i));
    cyc("mid_d", 0, 1, 8'h00);
    cyc("mid_d", 0, 1, 8'h00);
    cyc("emp_wr", 1, 1, 8'h30);
    for (int i = 0; i < 3; i++) cyc("to_full", 1, 0, 8'h31 + 8'(i));
    cyc("full_wr", 1, 1, 8'h3F);
    for (int i = 0; i < 3; i++) cyc("full_d", 0, 1, 8'h00);
    do_clr("clr2");

    // Pointer wrap with interleaved reads
    for (int i = 0; i < 20; i++) begin
      cyc("wrap", 1, q.size() >= 2, 8'(i));
    end
    while (q.size() > 0) cyc("wrap_d", 0, 1, 8'h00);
    cyc("wrap_end", 0, 0, 8'h00);

    // First-word-fall-through instance
    b_we = 1'b1; b_din = 8'h55;
    tick();
    b_we = 1'b0;
    chk("fwft.empty", 32'(b_empty), 32'h0);
    chk("fwft.dout", 32'(b_dout), 32'h55);
    b_we = 1'b1; b_din = 8'h66;
    tick();
    b_we = 1'b0;
    chk("fwft.head", 32'(b_dout), 32'h55);
    chk("fwft.count2", 32'(b_count), 32'h2);
    b_re = 1'b1;
    tick();
    chk("fwft.next", 32'(b_dout), 32'h66);
    chk("fwft.nonempty", 32'(b_empty), 32'h0);
    tick();
    b_re = 1'b0;
    chk("fwft.empty2", 32'(b_empty), 32'h1);
    chk("fwft.unf0", 32'(b_unf), 32'h0);
    b_we = 1'b1; b_din = 8'h77;
    tick();
    b_din = 8'h88;
    tick();
    b_we = 1'b0;
    chk("fwft.count_pre", 32'(b_count), 32'h2);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("fwft.clr_empty", 32'(b_empty), 32'h1);
    chk("fwft.clr_count", 32'(b_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
